// File: rtl/digit_serial_pkg.sv
// Shared types and constants for the digit-serial adder: FSM states, digit size
// and the digit-counter width helper.
package digit_serial_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DIGIT_BITS = 2;

   // Counter must index WIDTH/2 digits; keep at least one bit for WIDTH=2.
   function automatic int cnt_width(input int width);
      int ndig;
      ndig = width / DIGIT_BITS;
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/FA_2bit.sv
// Combinational 2-bit ripple-carry adder slice.
// Zero latency; no flow control.
module FA_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] sum,
   output logic       cout
);

   logic c0;

   assign sum[0] = a[0] ^ b[0] ^ cin;
   assign c0     = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
   assign sum[1] = a[1] ^ b[1] ^ c0;
   assign cout   = (a[1] & b[1]) | (a[1] & c0) | (b[1] & c0);

endmodule

// File: rtl/digit_serial_adder.sv
// WIDTH-bit adder built from one 2-bit slice, one digit per clock; done pulses WIDTH/2
// edges after the accepted start. start is only honoured in IDLE; no queuing.
module digit_serial_adder
   import digit_serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NDIG = WIDTH / DIGIT_BITS;
   localparam int CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("digit_serial_adder: WIDTH must be even and >= 2");
   end

   state_t                  state, nstate;
   logic [WIDTH-1:0]        sa, sb, part, part_nxt;
   logic                    cy;
   logic [CW-1:0]           cnt;
   logic [DIGIT_BITS-1:0]   d_sum;
   logic                    d_cout;
   logic                    load, step, last;

   FA_2bit u_slice (
      .a    (sa[1:0]),
      .b    (sb[1:0]),
      .cin  (cy),
      .sum  (d_sum),
      .cout (d_cout)
   );

   // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
   assign part_nxt = WIDTH'({d_sum, part} >> DIGIT_BITS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      load   = 1'b0;
      step   = 1'b0;
      last   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load   = 1'b1;
               nstate = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST) begin
               last   = 1'b1;
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa   <= '0;
         sb   <= '0;
         cy   <= 1'b0;
         cnt  <= '0;
         part <= '0;
         sum  <= '0;
         cout <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= last;
         if (load) begin
            sa   <= a;
            sb   <= b;
            cy   <= cin;
            cnt  <= '0;
            part <= '0;
         end else if (step) begin
            sa   <= sa >> DIGIT_BITS;
            sb   <= sb >> DIGIT_BITS;
            cy   <= d_cout;
            cnt  <= cnt + CW'(1);
            part <= part_nxt;
         end
         if (last) begin
            sum  <= part_nxt;
            cout <= d_cout;
         end
      end
   end

endmodule
